mod_inv: RTL and testbench
==========================

MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 SHALL have parameter Q, default 3329, the Kyber modulus; only 3329 is supported.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port r, input, 1 bit, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, request to invert A; sampled only in IDLE.
REQ-005 SHALL have port A, input, 12 bits, unsigned operand in the range 0..4095.
REQ-006 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit, one-cycle pulse marking OUT valid.
REQ-008 SHALL have port OUT, output, 12 bits, A^-1 mod Q in the range 0..3328, held until the next accepted start.
REQ-009 SHALL have port err, output, 1 bit, high with done when A mod Q = 0; held like OUT.

Function
REQ-010 SHALL compute A^(Q-2) mod Q (Fermat), exponent 3327 = 12'b1100_1111_1111, by left-to-right square-and-multiply.
REQ-011 SHALL register A on the start-accept edge, then normalise it in LOAD: if A >= Q, base = A - Q.
REQ-012 SHALL seed acc = base for exponent bit 11, then for bits 10..0 apply acc = acc^2 and, if the bit is 1, acc = acc*base; this is 20 multiplies in total.
REQ-013 SHALL issue each multiply to the pipelined multiplier with valid_in high for 1 cycle and capture the product on valid_out (3 cycles later), giving exactly 4 cycles per multiply.
REQ-014 SHALL use FSM states IDLE -> LOAD -> SQR -> MUL (MUL only if the current exponent bit is 1) -> next bit, and -> FIN after bit 0, then back to IDLE.
REQ-015 SHALL pulse done in FIN exactly 82 cycles after the start-accept edge: 1 LOAD + 80 multiply cycles + 1 FIN.
REQ-016 SHALL ignore start while busy = 1; there is no queuing.
REQ-017 SHALL accept a start asserted in the same cycle as done's FIN-to-IDLE transition only on the following IDLE cycle.
REQ-018 SHALL use a 4-bit bit counter that counts down from 10 to 0; it SHALL NOT wrap.
REQ-019 SHALL keep all intermediate values below Q: multiplier outputs are fully reduced, and no result above 3328 is ever presented on OUT.

Reset
REQ-020 SHALL, with r low, force FSM = IDLE, busy = 0, done = 0, err = 0, OUT = 0, acc = 0 and base = 0, and drive ~r to the multiplier's active-high reset.
REQ-021 SHALL abort any operation in progress on reset; on release, OUT = 0 and no done pulse appears for the aborted job.

Configuration
REQ-022 SHALL, with macro MOD_INV_ZERO_CHECK_EN defined, detect base = 0 in LOAD and go directly to FIN: done pulses 2 cycles after accept, with OUT = 0 and err = 1.
REQ-023 SHALL, without MOD_INV_ZERO_CHECK_EN, run the full 82-cycle sequence for base = 0, giving OUT = 0, with err tied to 0.

Structure
REQ-024 SHALL take Q, the exponent constant 3327, the latency 82 and the FSM state encodings from the shared Kyber parameter package.
REQ-025 SHALL instantiate exactly one sub-module, Mod_mul (the 3-stage modular multiplier), shared between squaring and multiplying via operand muxes.

Verification
REQ-026 SHALL check: A = 1 -> OUT = 1, err = 0, done exactly 82 cycles after accept.
REQ-027 SHALL check: A = 2 -> OUT = 1665; A = 17 -> OUT = 1175; A = 3328 -> OUT = 3328.
REQ-028 SHALL check: A = 3330 (normalised to 1) -> OUT = 1; A = 3331 -> OUT = 1665.
REQ-029 SHALL check: A = 0 and A = 3329 -> with the macro, done after 2 cycles with OUT = 0, err = 1; without it, done at 82 cycles with OUT = 0, err = 0.
REQ-030 SHALL check: start re-asserted at cycle 40 with A = 5 -> ignored, and the original result is unaffected.
REQ-031 SHALL check: r pulled low at cycle 30 -> all outputs 0 and no done; a new start after release with A = 2 -> OUT = 1665 at cycle 82.

Source files
------------

// File: rtl/mod_inv_pkg.sv
// Shared Kyber parameters for the modular inverter: modulus, Fermat
// exponent, job latency and FSM state encodings.
package mod_inv_pkg;

    localparam int          KYBER_Q     = 3329;
    localparam logic [11:0] INV_EXP     = 12'd3327;   // Q-2 = 12'b1100_1111_1111
    localparam int          INV_LATENCY = 82;         // accept edge to done cycle
    localparam logic [3:0]  BIT_TOP     = 4'd10;      // bit 11 is folded into the seed

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SQR  = 3'd2,
        ST_MUL  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/Mod_mul.sv
// Three-stage modular multiplier, p = a*b mod Q with a, b < Q.
// Stage 1 forms the raw product, stage 2 the Barrett quotient estimate,
// stage 3 the remainder with a single correction subtract.
module Mod_mul
    import mod_inv_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        valid_out,
    output logic [11:0] p
);

    localparam logic [12:0] Q13       = 13'(Q);
    // floor(2^24 / Q); the estimate is at most one short of the true
    // quotient, so one conditional subtract fully reduces the result
    localparam logic [12:0] BARRETT_M = 13'((1 << 24) / Q);

    logic [23:0] prod1;
    logic [23:0] prod2;
    logic [11:0] q2;
    logic        v1;
    logic        v2;
    logic [23:0] q_times_m;
    logic [12:0] rem0;
    logic [12:0] rem_fix;

    // remainder from the quotient estimate, then the final correction
    always_comb begin
        q_times_m = {12'b0, q2} * {11'b0, Q13};
        rem0      = 13'(prod2 - q_times_m);
        rem_fix   = (rem0 >= Q13) ? rem0 - Q13 : rem0;
    end

    // pipeline registers; the valid bit travels alongside the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod1     <= '0;
            prod2     <= '0;
            q2        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
            p         <= '0;
        end else begin
            v1        <= valid_in;
            prod1     <= {12'b0, a} * {12'b0, b};
            v2        <= v1;
            prod2     <= prod1;
            q2        <= 12'(({13'b0, prod1} * {24'b0, BARRETT_M}) >> 24);
            valid_out <= v2;
            p         <= 12'(rem_fix);
        end
    end

endmodule

// File: rtl/mod_inv.sv
// Modular inverse A^-1 mod 3329 via Fermat (A^3327) using left-to-right
// square-and-multiply on one shared Mod_mul instance.
// Optional build macro MOD_INV_ZERO_CHECK_EN: short-circuits base = 0
// straight to FIN with err = 1; without it err is tied low.
//
// state | meaning
// IDLE  | waiting for start, busy low
// LOAD  | normalise registered A into base, seed acc
// SQR   | acc = acc*acc for the current exponent bit
// MUL   | acc = acc*base when the current exponent bit is 1
// FIN   | one-cycle done pulse, OUT/err valid
module mod_inv
    import mod_inv_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic        clk,
    input  logic        r,
    input  logic        start,
    input  logic [11:0] A,
    output logic        busy,
    output logic        done,
    output logic [11:0] OUT,
    output logic        err
);

    localparam logic [11:0] Q12 = 12'(Q);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] a_reg;
    logic [11:0] a_norm;
    logic [11:0] base;
    logic [11:0] acc;
    logic [11:0] out_reg;
    logic [3:0]  bit_cnt;
    logic [1:0]  ph;
    logic        mul_vin;
    logic        mul_vout;
    logic [11:0] mul_b;
    logic [11:0] mul_p;

    assign a_norm  = (a_reg >= Q12) ? a_reg - Q12 : a_reg;
    assign mul_vin = ((state == ST_SQR) || (state == ST_MUL)) && (ph == 2'd0);
    assign mul_b   = (state == ST_MUL) ? base : acc;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FIN);
    assign OUT     = out_reg;

    Mod_mul #(.Q(Q)) u_mul (
        .clk       (clk),
        .rst       (~r),
        .valid_in  (mul_vin),
        .a         (acc),
        .b         (mul_b),
        .valid_out (mul_vout),
        .p         (mul_p)
    );

    // state register
    always_ff @(posedge clk or negedge r) begin
        if (!r) state <= ST_IDLE;
        else    state <= state_nxt;
    end

    // next-state: each multiply step advances only when its product returns
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                state_nxt = ST_SQR;
`ifdef MOD_INV_ZERO_CHECK_EN
                if (a_norm == '0) state_nxt = ST_FIN;
`endif
            end
            ST_SQR: begin
                if (mul_vout) begin
                    if (INV_EXP[bit_cnt])    state_nxt = ST_MUL;
                    else if (bit_cnt == '0)  state_nxt = ST_FIN;
                    else                     state_nxt = ST_SQR;
                end
            end
            ST_MUL: begin
                if (mul_vout) begin
                    if (bit_cnt == '0) state_nxt = ST_FIN;
                    else               state_nxt = ST_SQR;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // datapath: operand capture, accumulator, bit counter and result hold
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            a_reg   <= '0;
            base    <= '0;
            acc     <= '0;
            out_reg <= '0;
            bit_cnt <= '0;
            ph      <= '0;
        end else begin
            ph <= ((state == ST_SQR) || (state == ST_MUL)) ? ph + 2'd1 : 2'd0;
            case (state)
                ST_IDLE: if (start) a_reg <= A;
                ST_LOAD: begin
                    base    <= a_norm;
                    acc     <= a_norm;
                    bit_cnt <= BIT_TOP;
`ifdef MOD_INV_ZERO_CHECK_EN
                    if (a_norm == '0) out_reg <= '0;
`endif
                end
                ST_SQR, ST_MUL: begin
                    if (mul_vout) begin
                        acc <= mul_p;
                        if (state_nxt == ST_FIN) out_reg <= mul_p;
                        if (state_nxt == ST_SQR) bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MOD_INV_ZERO_CHECK_EN
    logic err_reg;

    // err is set by the zero short-cut and cleared by any real result
    always_ff @(posedge clk or negedge r) begin
        if (!r)
            err_reg <= 1'b0;
        else if ((state == ST_LOAD) && (a_norm == '0))
            err_reg <= 1'b1;
        else if (((state == ST_SQR) || (state == ST_MUL)) && mul_vout && (state_nxt == ST_FIN))
            err_reg <= 1'b0;
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_inv.sv
// Directed bench for mod_inv: vector table of operands with hand-computed
// inverses, plus sequences for ignored start, start during FIN and reset abort.
module tb_mod_inv;
    import mod_inv_pkg::*;

`ifdef MOD_INV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif
    localparam int ZERO_LAT = ZC ? 2 : INV_LATENCY;

    logic        clk;
    logic        r;
    logic        start;
    logic [11:0] A;
    logic        busy;
    logic        done;
    logic [11:0] OUT;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    mod_inv #(.Q(3329)) dut (
        .clk   (clk),
        .r     (r),
        .start (start),
        .A     (A),
        .busy  (busy),
        .done  (done),
        .OUT   (OUT),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [11:0] out;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // drive start for one accept edge; returns #1 into cycle 1 (LOAD)
    task automatic start_job(input logic [11:0] a_in);
        @(negedge clk);
        start = 1'b1;
        A     = a_in;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // counts cycles from cycle 1 until done, optionally poking start mid-job
    task automatic wait_done(input int poke_at, output int lat);
        lat = 1;
        while (!done && lat < 200) begin
            if (lat == poke_at) begin
                start = 1'b1;
                A     = 12'd5;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int   lat;
        logic seen;

        vecs[0] = '{a: 12'd1,    out: 12'd1,    err: 1'b0, lat: INV_LATENCY};
        vecs[1] = '{a: 12'd2,    out: 12'd1665, err: 1'b0, lat: INV_LATENCY};
        vecs[2] = '{a: 12'd17,   out: 12'd1175, err: 1'b0, lat: INV_LATENCY};
        vecs[3] = '{a: 12'd3328, out: 12'd3328, err: 1'b0, lat: INV_LATENCY};
        vecs[4] = '{a: 12'd3330, out: 12'd1,    err: 1'b0, lat: INV_LATENCY};
        vecs[5] = '{a: 12'd3331, out: 12'd1665, err: 1'b0, lat: INV_LATENCY};
        vecs[6] = '{a: 12'd0,    out: 12'd0,    err: ZC,   lat: ZERO_LAT};
        vecs[7] = '{a: 12'd3,    out: 12'd1110, err: 1'b0, lat: INV_LATENCY};
        vecs[8] = '{a: 12'd3329, out: 12'd0,    err: ZC,   lat: ZERO_LAT};
        vecs[9] = '{a: 12'd4,    out: 12'd2497, err: 1'b0, lat: INV_LATENCY};

        r     = 1'b0;
        start = 1'b0;
        A     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out",  OUT,  0);
        check("rst_err",  err,  0);
        @(negedge clk);
        r = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            start_job(vecs[i].a);
            check($sformatf("busy_a%0d", vecs[i].a), busy, 1);
            wait_done(0, lat);
            check($sformatf("out_a%0d", vecs[i].a), OUT, vecs[i].out);
            check($sformatf("err_a%0d", vecs[i].a), err, vecs[i].err);
            check($sformatf("lat_a%0d", vecs[i].a), lat, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("pulse_end_a%0d", vecs[i].a), {done, busy}, 0);
        end

        // start re-asserted at cycle 40 with A = 5 must not disturb the job
        start_job(12'd17);
        wait_done(40, lat);
        check("poke_out", OUT, 1175);
        check("poke_lat", lat, INV_LATENCY);
        @(posedge clk);
        #1;
        check("poke_idle", busy, 0);

        // start held through the FIN cycle is only taken on the next IDLE cycle
        start_job(12'd3);
        wait_done(0, lat);
        check("fin_lat", lat, INV_LATENCY);
        start = 1'b1;
        A     = 12'd2;
        @(posedge clk);
        #1;
        check("fin_start_not_taken", busy, 0);
        @(posedge clk);
        #1;
        check("fin_start_taken", busy, 1);
        start = 1'b0;
        wait_done(0, lat);
        check("fin_next_out", OUT, 1665);
        check("fin_next_lat", lat, INV_LATENCY);
        @(posedge clk);

        // reset at cycle 30 aborts the job; a fresh job afterwards is clean
        start_job(12'd17);
        for (int c = 1; c < 30; c++) begin
            @(posedge clk);
            #1;
        end
        r = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out",  OUT,  0);
        check("abort_err",  err,  0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen = seen | done | busy;
        end
        @(negedge clk);
        r = 1'b1;
        repeat (90) begin
            @(posedge clk);
            #1;
            seen = seen | done | busy;
        end
        check("abort_no_done", seen, 0);
        check("abort_out_held", OUT, 0);
        start_job(12'd2);
        wait_done(0, lat);
        check("post_rst_out", OUT, 1665);
        check("post_rst_lat", lat, INV_LATENCY);
        check("post_rst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
